// File: rtl/twos_neg_pkg.sv
// Shared definitions for the two-requester negation arbiter.
// State encodings plus helpers for the W-dependent range limits (W <= 32).
package twos_neg_pkg;

    localparam int DEF_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    // -2^(w-1) as a raw bit pattern: MSB set, everything else clear
    function automatic logic [31:0] min_neg(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] max_pos(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/twos_negate.sv
// Combinational two's-complement negation with overflow detect.
// TWOS_NEG_SAT_EN: the unrepresentable -2^(W-1) case saturates to 2^(W-1)-1.
module twos_negate
    import twos_neg_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] op,
    output logic [W-1:0] neg,
    output logic         ovf
);

    localparam logic [W-1:0] MIN_NEG = W'(min_neg(W));

    assign ovf = (op == MIN_NEG);

`ifdef TWOS_NEG_SAT_EN
    localparam logic [W-1:0] MAX_POS = W'(max_pos(W));
    assign neg = ovf ? MAX_POS : (~op + W'(1));
`else
    assign neg = ~op + W'(1);
`endif

endmodule

// File: rtl/twos_neg_arbiter.sv
// Round-robin arbiter sharing one negation unit between two requesters.
// Build option TWOS_NEG_SAT_EN selects saturation of the overflow case.
//
//   state | meaning
//   IDLE  | waiting for a valid operand; winner's ready asserted this cycle
//   CALC  | captured operand passes through the negation unit into result regs
//   OUT   | result presented, held until res_ready
module twos_neg_arbiter
    import twos_neg_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_id,
    output logic         res_ovf,
    input  logic         res_ready
);

    logic [1:0]   state;
    logic         last_grant;
    logic         grant0;
    logic         grant1;
    logic         idle_ok;
    logic [W-1:0] op_reg;
    logic         op_id;
    logic [W-1:0] neg;
    logic         neg_ovf;

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        grant1 = req1_valid && (!req0_valid || !last_grant);
        grant0 = req0_valid && !grant1;
    end

    // Gated by rst_n so nothing is acknowledged while reset is held.
    assign idle_ok    = rst_n && (state == IDLE);
    assign req0_ready = idle_ok && grant0;
    assign req1_ready = idle_ok && grant1;
    assign res_valid  = (state == OUT);

    twos_negate #(.W(W)) u_negate (
        .op  (op_reg),
        .neg (neg),
        .ovf (neg_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_reg     <= '0;
            op_id      <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            res_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_reg     <= grant1 ? req1_data : req0_data;
                        op_id      <= grant1;
                        last_grant <= grant1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    res_data <= neg;
                    res_ovf  <= neg_ovf;
                    res_id   <= op_id;
                    state    <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twos_neg_arbiter.sv
// Directed self-checking bench for twos_neg_arbiter (W=8).
// Expects the overflow result to follow whichever TWOS_NEG_SAT_EN build is compiled.
module tb_twos_neg_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_id;
    logic       res_ovf;
    logic       res_ready;

    int checks;
    int failures;

`ifdef TWOS_NEG_SAT_EN
    localparam logic [7:0] OVF_RESULT = 8'h7F;
`else
    localparam logic [7:0] OVF_RESULT = 8'h80;
`endif

    twos_neg_arbiter #(.W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ovf    (res_ovf),
        .res_ready  (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; runs one full transaction.
    task automatic run_txn(input logic v0, input logic [7:0] d0,
                           input logic v1, input logic [7:0] d1,
                           input logic exp_id, input logic [7:0] exp_data,
                           input logic exp_ovf, input int hold);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        #1;
        check("req0_ready_idle", req0_ready, exp_id == 1'b0);
        check("req1_ready_idle", req1_ready, exp_id == 1'b1);
        @(negedge clk);
        check("calc_res_valid", res_valid, 0);
        check("calc_readys", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        check("out_res_valid", res_valid, 1);
        check("out_res_data", res_data, exp_data);
        check("out_res_id", res_id, exp_id);
        check("out_res_ovf", res_ovf, exp_ovf);
        check("out_readys", {req0_ready, req1_ready}, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", res_data, exp_data);
            check("hold_res_id", res_id, exp_id);
            check("hold_res_ovf", res_ovf, exp_ovf);
            check("hold_readys", {req0_ready, req1_ready}, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("post_hs_res_valid", res_valid, 0);
        res_ready = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h01;
        req1_valid = 1'b1;
        req1_data  = 8'h02;
        res_ready  = 1'b0;

        // Held in reset with both requesters valid
        repeat (2) @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_ovf", res_ovf, 0);
        rst_n = 1'b1;

        // Continuous contention: strict alternation starting with req0
        run_txn(1, 8'h01, 1, 8'h02, 0, 8'hFF, 0, 0);
        run_txn(1, 8'h01, 1, 8'h02, 1, 8'hFE, 0, 0);
        run_txn(1, 8'h01, 1, 8'h02, 0, 8'hFF, 0, 0);
        run_txn(1, 8'h01, 1, 8'h02, 1, 8'hFE, 0, 0);

        // Single requester, result held under backpressure
        run_txn(1, 8'h05, 0, 8'h00, 0, 8'hFB, 0, 5);
        // Lone req0 wins again despite having won last
        run_txn(1, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
        // Overflow operand
        run_txn(0, 8'h00, 1, 8'h80, 1, OVF_RESULT, 1, 2);
        // Lone req1 wins again; largest positive operand
        run_txn(0, 8'h00, 1, 8'h7F, 1, 8'h81, 0, 0);
        // Contention after req1 won: req0 next
        run_txn(1, 8'h33, 1, 8'h44, 0, 8'hCD, 0, 0);
        run_txn(1, 8'h33, 1, 8'h44, 1, 8'hBC, 0, 0);

        // Reset while a result is pending; last winner before reset is req0
        req0_valid = 1'b1;
        req0_data  = 8'h10;
        req1_valid = 1'b0;
        #1;
        check("pre_rst_req0_ready", req0_ready, 1);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_res_valid", res_valid, 1);
        check("pre_rst_res_data", res_data, 8'hF0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_res_valid", res_valid, 0);
        check("async_rst_res_data", res_data, 0);
        req0_valid = 1'b1;
        req0_data  = 8'h21;
        req1_valid = 1'b1;
        req1_data  = 8'h22;
        @(negedge clk);
        check("in_rst_res_valid", res_valid, 0);
        rst_n = 1'b1;
        run_txn(1, 8'h21, 1, 8'h22, 0, 8'hDF, 0, 0);
        @(negedge clk);
        check("no_stale_res_valid", res_valid, 0);

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
